sfp_port_sched: RTL and testbench
=================================

// Module: sfp_port_sched
// PURPOSE
//  Per-port bring-up sequencer for 8 SFP cages, fed by the debounced sfp_only/sfp_los status registers.
//  - Sequences each cage: insertion settle, ID read, TX enable.
//  - Shares a single I2C/EEPROM master between the 8 cages with a round-robin arbiter.
//  - Drives TX_DISABLE pins, per-port ready/fail flags and a sticky interrupt.
// PARAMETERS
//  NPORT        8   number of cages (port index width = 3)
//  SETTLE_TICKS 50  clk_100hz ticks from insertion to ID request (500 ms)
//  MAX_RETRY    3   I2C errors tolerated per insertion; the next error -> FAIL
// PORTS
//  clk           in   1  system clock
//  rst_n         in   1  reset: asynchronous, active-low
//  clk_100hz     in   1  one-clk-wide tick enable, 100 Hz
//  sfp_only_reg  in   8  filtered presence; 1 = cage empty
//  sfp_los_reg   in   8  filtered LOS; 1 = loss of signal
//  port_en       in   8  software enable per cage; 0 = treat cage as absent
//  i2c_req       out  1  request to shared I2C master (ID read)
//  i2c_port      out  3  cage selected for the current request
//  i2c_done      in   1  one-cycle pulse: transaction finished
//  i2c_err       in   1  qualified by i2c_done; 1 = NACK/checksum fail
//  sfp_tx_dis    out  8  TX_DISABLE pins; 1 = laser off
//  sfp_ready     out  8  cage in UP state
//  sfp_fail      out  8  cage in FAIL state
//  irq_clr       in   8  W1C pulse clearing irq_status bits
//  irq_status    out  8  sticky per-port change flags
//  irq           out  1  OR of irq_status
// BEHAVIOUR
//  Reset values
//   - sfp_tx_dis=8'hff; all other outputs 0.
//   - All ports in ABSENT; retry counters 0; RR pointer 0.
//  Per-port FSM, advanced on clk; the settle counter advances only on clk_100hz.
//   - ABSENT: present && port_en -> SETTLE, counter cleared.
//   - SETTLE: counter reaches SETTLE_TICKS -> WAIT_ID; the port then raises an internal request.
//   - WAIT_ID, on i2c_done for this port:
//       err=0 -> UP.
//       err=1 and retry<MAX_RETRY -> retry++, return to SETTLE.
//       err=1 and retry=MAX_RETRY -> FAIL.
//   - UP: tx_dis=0, ready=1.
//   - FAIL: tx_dis=1, fail=1; left only via removal or port_en=0.
//   - Any state, (absent || !port_en) -> ABSENT next clk:
//       tx_dis=1, ready=fail=0, retry=0.
//     This takes priority over every other transition.
//  Arbiter
//   - At most one outstanding transaction.
//   - When idle, grant the first requesting port at or after RR pointer, wrapping 7->0.
//   - Next cycle: i2c_req=1, i2c_port=winner. Both are held stable until i2c_done.
//   - On i2c_done: i2c_req=0 that same edge; RR pointer = winner+1 mod 8.
//   - At least one idle cycle between transactions.
//   - Granted port removed mid-transaction: request is not aborted; the result on i2c_done is discarded.
//  Interrupts
//   - irq_status[i] sets on entry to UP, on entry to FAIL, and on leaving UP/FAIL.
//   - irq_clr clears bits; a set and a clear in the same cycle -> set wins.
//   - irq is registered: one cycle after irq_status.
//  Ticks
//   - clk_100hz high for >1 cycle is illegal.
//   - A tick coinciding with a state change is ignored by the new state.
// CONFIGURATION
//  SFP_LOS_TXDIS_EN defined
//   - In UP, sfp_tx_dis[i] = sfp_los_reg[i] (automatic laser shutdown); sfp_ready unaffected.
//  SFP_LOS_TXDIS_EN undefined
//   - sfp_los_reg is unused; tx_dis depends only on FSM state.
// STRUCTURE
//  Package sfp_pkg
//   - port_state_t enum {ABSENT,SETTLE,WAIT_ID,UP,FAIL}.
//   - SFP_NPORT, SFP_IDX_W constants.
//  Sub-module sfp_rr_arb
//   - NPORT-bit request vector in, one-hot grant plus index out, pointer update on done.
//  Per-port FSMs generated with a generate loop in the top level.
// TESTING
//  - Insert port 2 (only_reg[2]=0, en=ff) -> i2c_req with port=2 after exactly 50 ticks;
//    done/err=0 -> tx_dis[2]=0, ready[2]=1, irq_status=8'h04.
//  - Ports 1,5,6 settle on the same tick, RR pointer=6 -> grants in order 6,1,5;
//    i2c_port stable while req high; >=1 idle cycle between grants.
//  - Port 3 returns err=1 four times -> re-settles 3x (50 ticks each), then fail[3]=1, tx_dis[3]=1.
//  - Remove port 4 while its request is outstanding -> ABSENT next clk, tx_dis[4]=1;
//    later done/err=0 is ignored and ready[4] stays 0.
//  - Port 0 UP, irq_clr=01 in same cycle port 0 removed -> irq_status[0] remains 1.
//  - SFP_LOS_TXDIS_EN: port 7 UP, los[7]=1 -> tx_dis[7]=1, ready[7]=1; los=0 -> tx_dis[7]=0.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared types and constants for the SFP cage bring-up slice.
package sfp_pkg;

  localparam int SFP_NPORT    = 8;
  localparam int SFP_IDX_W    = $clog2(SFP_NPORT);
  localparam int SETTLE_TICKS = 50;
  localparam int MAX_RETRY    = 3;
  localparam int SFP_CNT_W    = 6;
  localparam int SFP_RTY_W    = 2;

  typedef enum logic [2:0] {
    ABSENT,
    SETTLE,
    WAIT_ID,
    UP,
    FAIL
  } port_state_t;

endpackage

// File: rtl/sfp_rr_arb.sv
// Round-robin arbiter for the shared I2C master, one transaction at a time.
module sfp_rr_arb
  import sfp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SFP_NPORT-1:0] req,
  input  logic                 done,
  output logic                 busy,
  output logic [SFP_IDX_W-1:0] idx,
  output logic [SFP_NPORT-1:0] gnt
);

  logic [SFP_IDX_W-1:0] ptr;
  logic [SFP_IDX_W-1:0] pick;
  logic [SFP_IDX_W-1:0] j;
  logic                 hit;

  always_comb begin
    pick = ptr;
    hit  = 1'b0;
    j    = '0;
    for (int k = 0; k < SFP_NPORT; k++) begin
      j = ptr + k[SFP_IDX_W-1:0];
      if (!hit && req[j]) begin
        hit  = 1'b1;
        pick = j;
      end
    end
  end

  // busy drops on the done edge, so a new grant needs one idle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      idx  <= '0;
      gnt  <= '0;
      ptr  <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        gnt  <= '0;
        ptr  <= idx + 1'b1;
      end
    end else if (hit) begin
      busy <= 1'b1;
      idx  <= pick;
      gnt  <= SFP_NPORT'(1) << pick;
    end
  end

endmodule

// File: rtl/sfp_port_sched.sv
// Per-cage SFP bring-up sequencer with shared I2C arbitration and sticky irqs.
// Optional: SFP_LOS_TXDIS_EN gates TX_DISABLE with LOS while a cage is UP.
module sfp_port_sched
  import sfp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_100hz,
  input  logic [SFP_NPORT-1:0] sfp_only_reg,
  input  logic [SFP_NPORT-1:0] sfp_los_reg,
  input  logic [SFP_NPORT-1:0] port_en,
  output logic                 i2c_req,
  output logic [SFP_IDX_W-1:0] i2c_port,
  input  logic                 i2c_done,
  input  logic                 i2c_err,
  output logic [SFP_NPORT-1:0] sfp_tx_dis,
  output logic [SFP_NPORT-1:0] sfp_ready,
  output logic [SFP_NPORT-1:0] sfp_fail,
  input  logic [SFP_NPORT-1:0] irq_clr,
  output logic [SFP_NPORT-1:0] irq_status,
  output logic                 irq
);

  logic [SFP_NPORT-1:0] req;
  logic [SFP_NPORT-1:0] gnt;

  sfp_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (i2c_done),
    .busy  (i2c_req),
    .idx   (i2c_port),
    .gnt   (gnt)
  );

  for (genvar i = 0; i < SFP_NPORT; i++) begin : g_port
    port_state_t          st;
    logic [SFP_CNT_W-1:0] cnt;
    logic [SFP_RTY_W-1:0] rty;
    logic                 tx_q;
    logic                 rdy_q;
    logic                 fl_q;
    logic                 irq_q;
    logic                 present;
    logic                 my_done;

    assign present = ~sfp_only_reg[i] & port_en[i];
    // gnt is cleared on removal-independent done, so stale results land in ABSENT
    assign my_done = i2c_done & gnt[i];
    assign req[i]  = (st == WAIT_ID);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= ABSENT;
        cnt   <= '0;
        rty   <= '0;
        tx_q  <= 1'b1;
        rdy_q <= 1'b0;
        fl_q  <= 1'b0;
        irq_q <= 1'b0;
      end else begin
        if (irq_clr[i]) irq_q <= 1'b0;
        if (!present) begin
          st    <= ABSENT;
          cnt   <= '0;
          rty   <= '0;
          tx_q  <= 1'b1;
          rdy_q <= 1'b0;
          fl_q  <= 1'b0;
          if (st == UP || st == FAIL) irq_q <= 1'b1;
        end else begin
          unique case (st)
            ABSENT: begin
              st  <= SETTLE;
              cnt <= '0;
            end
            SETTLE: begin
              if (clk_100hz) begin
                if (cnt == SFP_CNT_W'(SETTLE_TICKS - 1)) st <= WAIT_ID;
                else cnt <= cnt + 1'b1;
              end
            end
            WAIT_ID: begin
              if (my_done) begin
                if (!i2c_err) begin
                  st    <= UP;
                  tx_q  <= 1'b0;
                  rdy_q <= 1'b1;
                  irq_q <= 1'b1;
                end else if (rty == SFP_RTY_W'(MAX_RETRY)) begin
                  st    <= FAIL;
                  fl_q  <= 1'b1;
                  irq_q <= 1'b1;
                end else begin
                  rty <= rty + 1'b1;
                  cnt <= '0;
                  st  <= SETTLE;
                end
              end
            end
            UP, FAIL: ;
            default: st <= ABSENT;
          endcase
        end
      end
    end

`ifdef SFP_LOS_TXDIS_EN
    assign sfp_tx_dis[i] = tx_q | (rdy_q & sfp_los_reg[i]);
`else
    assign sfp_tx_dis[i] = tx_q;
`endif
    assign sfp_ready[i]  = rdy_q;
    assign sfp_fail[i]   = fl_q;
    assign irq_status[i] = irq_q;
  end

`ifndef SFP_LOS_TXDIS_EN
  logic unused_los;
  assign unused_los = ^sfp_los_reg;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |irq_status;
  end

endmodule

// File: tb/tb_sfp_port_sched.sv
// Directed bench for sfp_port_sched: settle, RR order, retry/fail, removal, irq.
module tb_sfp_port_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_100hz = 1'b0;
  logic [7:0] sfp_only_reg = 8'hff;
  logic [7:0] sfp_los_reg = 8'h00;
  logic [7:0] port_en = 8'hff;
  logic       i2c_req;
  logic [2:0] i2c_port;
  logic       i2c_done = 1'b0;
  logic       i2c_err = 1'b0;
  logic [7:0] sfp_tx_dis;
  logic [7:0] sfp_ready;
  logic [7:0] sfp_fail;
  logic [7:0] irq_clr = 8'h00;
  logic [7:0] irq_status;
  logic       irq;

  int errors = 0;
  int checks = 0;

  sfp_port_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_100hz    (clk_100hz),
    .sfp_only_reg (sfp_only_reg),
    .sfp_los_reg  (sfp_los_reg),
    .port_en      (port_en),
    .i2c_req      (i2c_req),
    .i2c_port     (i2c_port),
    .i2c_done     (i2c_done),
    .i2c_err      (i2c_err),
    .sfp_tx_dis   (sfp_tx_dis),
    .sfp_ready    (sfp_ready),
    .sfp_fail     (sfp_fail),
    .irq_clr      (irq_clr),
    .irq_status   (irq_status),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk) clk_100hz = 1'b1;
      @(negedge clk) clk_100hz = 1'b0;
    end
  endtask

  task automatic clr_all();
    @(negedge clk) irq_clr = 8'hff;
    @(negedge clk) irq_clr = 8'h00;
  endtask

  task automatic serve(input int p, input logic err);
    int n;
    n = 0;
    while (!i2c_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", i2c_req, 1);
    chk("req_port", i2c_port, p);
    cyc(2);
    chk("port_hold", i2c_port, p);
    chk("req_hold", i2c_req, 1);
    i2c_done = 1'b1;
    i2c_err  = err;
    @(negedge clk);
    i2c_done = 1'b0;
    i2c_err  = 1'b0;
    chk("req_drop", i2c_req, 0);
  endtask

  task automatic bring_up(input int p);
    sfp_only_reg[p] = 1'b0;
    cyc(2);
    ticks(50);
    serve(p, 1'b0);
  endtask

  initial begin
    cyc(2);
    chk("rst_txdis", sfp_tx_dis, 8'hff);
    chk("rst_ready", sfp_ready, 0);
    chk("rst_fail", sfp_fail, 0);
    chk("rst_irqst", irq_status, 0);
    chk("rst_req", i2c_req, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;
    cyc(2);

    // port 2: no request before tick 50, request right after it
    sfp_only_reg[2] = 1'b0;
    cyc(2);
    ticks(49);
    cyc(3);
    chk("p2_early", i2c_req, 0);
    ticks(1);
    cyc(1);
    chk("p2_req", i2c_req, 1);
    chk("p2_port", i2c_port, 2);
    serve(2, 1'b0);
    chk("p2_txdis", sfp_tx_dis[2], 0);
    chk("p2_ready", sfp_ready[2], 1);
    chk("p2_irqst", irq_status, 8'h04);
    chk("p2_irq_lag", irq, 0);
    cyc(1);
    chk("p2_irq", irq, 1);
    clr_all();
    chk("p2_clr", irq_status, 0);

    // port 5 alone moves RR pointer to 6, then 1,5,6 settle together
    bring_up(5);
    sfp_only_reg[5] = 1'b1;
    cyc(2);
    chk("p5_gone", sfp_ready[5], 0);
    sfp_only_reg[1] = 1'b0;
    sfp_only_reg[5] = 1'b0;
    sfp_only_reg[6] = 1'b0;
    cyc(2);
    ticks(50);
    serve(6, 1'b0);
    serve(1, 1'b0);
    serve(5, 1'b0);
    chk("rr_ready", sfp_ready, 8'h66);

    // port 3: four errors -> three re-settles then FAIL
    sfp_only_reg[3] = 1'b0;
    cyc(2);
    for (int r = 0; r < 4; r++) begin
      ticks(49);
      cyc(3);
      chk("p3_early", i2c_req, 0);
      ticks(1);
      serve(3, 1'b1);
      chk("p3_fail", sfp_fail[3], (r == 3) ? 1 : 0);
    end
    chk("p3_txdis", sfp_tx_dis[3], 1);
    chk("p3_ready", sfp_ready[3], 0);

    // port 4 removed while its request is outstanding
    sfp_only_reg[4] = 1'b0;
    cyc(2);
    ticks(50);
    cyc(2);
    chk("p4_req", i2c_req, 1);
    chk("p4_port", i2c_port, 4);
    sfp_only_reg[4] = 1'b1;
    cyc(1);
    chk("p4_txdis", sfp_tx_dis[4], 1);
    chk("p4_held", i2c_req, 1);
    i2c_done = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0;
    chk("p4_drop", i2c_req, 0);
    cyc(2);
    chk("p4_ready", sfp_ready[4], 0);
    chk("p4_irq", irq_status[4], 0);

    // port 0: clear and removal in the same cycle, set wins
    bring_up(0);
    clr_all();
    chk("p0_clr", irq_status, 0);
    @(negedge clk);
    sfp_only_reg[0] = 1'b1;
    irq_clr = 8'h01;
    @(negedge clk);
    irq_clr = 8'h00;
    chk("p0_irq", irq_status[0], 1);
    chk("p0_txdis", sfp_tx_dis[0], 1);
    chk("p0_ready", sfp_ready[0], 0);

    // port 7: LOS while UP
    bring_up(7);
    chk("p7_ready", sfp_ready[7], 1);
    sfp_los_reg[7] = 1'b1;
    cyc(1);
`ifdef SFP_LOS_TXDIS_EN
    chk("p7_los_tx", sfp_tx_dis[7], 1);
`else
    chk("p7_los_tx", sfp_tx_dis[7], 0);
`endif
    chk("p7_los_rdy", sfp_ready[7], 1);
    sfp_los_reg[7] = 1'b0;
    cyc(1);
    chk("p7_ok_tx", sfp_tx_dis[7], 0);

    // port_en=0 forces ABSENT on an UP cage
    port_en[7] = 1'b0;
    cyc(1);
    chk("p7_dis_tx", sfp_tx_dis[7], 1);
    chk("p7_dis_rdy", sfp_ready[7], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
